fp_div_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider (FDIV.S) that fills the unused FP ALU control code 4'd3.
- Acts as a responder to the core's FP execute stage: the core issues a request with a one-cycle start pulse; the block answers with busy, then a one-cycle done pulse with the result and exception flags.
- Uses radix-2 restoring mantissa division with round-to-nearest-even.

---
 rtl/fp_div_seq_if.sv | 20 ++
 rtl/fp_div_seq.sv | 180 ++++++++++++++++++
 tb/tb_fp_div_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_if.sv
// Request/response bundle between the FP execute stage and the FDIV.S unit.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  fflags;

    modport master (
        output start, a, b,
        input  busy, done, result, fflags
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, fflags
    );
endinterface

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider (FDIV.S).
// Radix-2 restoring mantissa division, round-to-nearest-even, flush-to-zero.
module fp_div_seq #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000,
    parameter int unsigned QBITS     = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             state, state_nxt;
    logic               sign_r;
    logic [23:0]        mb_r;
    logic [24:0]        rem_r;
    logic [QBITS-1:0]   q_r;
    logic [4:0]         cnt_r;
    logic signed [9:0]  exp_r;
    logic [31:0]        result_r;
    logic [4:0]         fflags_r;

    // Operand classification of the live inputs (only used on the start edge)
    logic        s_res;
    logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic        sp_hit;
    logic [31:0] sp_result;
    logic [4:0]  sp_flags;

    // Special-operand decode: NaN, zero, infinity handling resolved in one cycle
    always_comb begin
        s_res     = bus.a[31] ^ bus.b[31];
        a_nan     = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != '0);
        b_nan     = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != '0);
        a_snan    = a_nan && !bus.a[22];
        b_snan    = b_nan && !bus.b[22];
        a_inf     = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == '0);
        b_inf     = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == '0);
        a_zero    = (bus.a[30:23] == 8'h00);
        b_zero    = (bus.b[30:23] == 8'h00);
        sp_hit    = 1'b1;
        sp_result = CANON_NAN;
        sp_flags  = '0;
        if (a_nan || b_nan) begin
            sp_flags = {a_snan || b_snan, 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_result = {s_res, 8'hFF, 23'd0};
        end else if (b_zero) begin
            sp_result = {s_res, 8'hFF, 23'd0};
            sp_flags  = 5'b01000;
        end else if (a_zero || b_inf) begin
            sp_result = {s_res, 31'd0};
        end else begin
            sp_hit    = 1'b0;
        end
    end

    // One restoring-division step
    logic        ge;
    logic [24:0] rem_nxt;

    // Compare, conditionally subtract, then shift the partial remainder
    always_comb begin
        ge      = rem_r >= {1'b0, mb_r};
        rem_nxt = (ge ? rem_r - {1'b0, mb_r} : rem_r) << 1;
    end

    // Normalisation and rounding
    logic [23:0]       mant_pre;
    logic              g_bit, r_bit, s_bit, rnd_up;
    logic [24:0]       mant_rnd;
    logic [22:0]       frac_fin;
    logic signed [9:0] exp_n, exp_fin;
    logic [31:0]       norm_result;
    logic [4:0]        norm_flags;

    // Normalise quotient, apply RNE, then check exponent range
    always_comb begin
        if (q_r[QBITS-1]) begin
            mant_pre = q_r[QBITS-1:QBITS-24];
            g_bit    = q_r[QBITS-25];
            r_bit    = q_r[QBITS-26];
            exp_n    = exp_r;
        end else begin
            mant_pre = q_r[QBITS-2:QBITS-25];
            g_bit    = q_r[QBITS-26];
            r_bit    = 1'b0;
            exp_n    = exp_r - 10'sd1;
        end
        s_bit    = rem_r != '0;
        rnd_up   = g_bit && (r_bit || s_bit || mant_pre[0]);
        mant_rnd = {1'b0, mant_pre} + 25'(rnd_up);
        if (mant_rnd[24]) begin
            frac_fin = mant_rnd[23:1];
            exp_fin  = exp_n + 10'sd1;
        end else begin
            frac_fin = mant_rnd[22:0];
            exp_fin  = exp_n;
        end
        if (exp_fin >= 10'sd255) begin
            norm_result = {sign_r, 8'hFF, 23'd0};
            norm_flags  = 5'b00101;
        end else if (exp_fin <= 10'sd0) begin
            norm_result = {sign_r, 31'd0};
            norm_flags  = 5'b00011;
        end else begin
            norm_result = {sign_r, exp_fin[7:0], frac_fin};
            norm_flags  = {4'b0000, g_bit || r_bit || s_bit};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = sp_hit ? DONE : DIV;
            DIV:  if (cnt_r == 5'(QBITS - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.busy   = (state == DIV) || (state == NORM);
        bus.done   = (state == DONE);
        bus.result = result_r;
        bus.fflags = fflags_r;
    end

    // Datapath: latch operands, iterate quotient bits, capture the final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            mb_r     <= '0;
            rem_r    <= '0;
            q_r      <= '0;
            cnt_r    <= '0;
            exp_r    <= '0;
            result_r <= '0;
            fflags_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sign_r <= s_res;
                    mb_r   <= {1'b1, bus.b[22:0]};
                    rem_r  <= {2'b01, bus.a[22:0]};
                    q_r    <= '0;
                    cnt_r  <= '0;
                    exp_r  <= $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;
                    if (sp_hit) begin
                        result_r <= sp_result;
                        fflags_r <= sp_flags;
                    end
                end
                DIV: begin
                    q_r   <= {q_r[QBITS-2:0], ge};
                    rem_r <= rem_nxt;
                    cnt_r <= cnt_r + 5'd1;
                end
                NORM: begin
                    result_r <= norm_result;
                    fflags_r <= norm_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, protocol cases and
// randomized operands checked against an exact-arithmetic reference model.
module tb_fp_div_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fp_div_seq_if bus();

    fp_div_seq #(.CANON_NAN(32'h7FC00000), .QBITS(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact quotient with many extra bits, IEEE RNE on the exact value
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output bit special);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned ma, mb, num, qv, mant, low, half;
        bit st, up, nx;
        int e, sh;
        s = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        a_nan = (ea == 8'hFF) && (fa != 0); b_nan = (eb == 8'hFF) && (fb != 0);
        a_snan = a_nan && !fa[22];          b_snan = b_nan && !fb[22];
        a_inf = (ea == 8'hFF) && (fa == 0); b_inf = (eb == 8'hFF) && (fb == 0);
        a_zero = (ea == 0);                 b_zero = (eb == 0);
        special = 1;
        f = 5'b0;
        if (a_nan || b_nan) begin
            r = 32'h7FC00000; f = {a_snan || b_snan, 4'b0};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 32'h7FC00000; f = 5'b10000;
        end else if (a_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (b_zero) begin
            r = {s, 8'hFF, 23'd0}; f = 5'b01000;
        end else if (a_zero || b_inf) begin
            r = {s, 31'd0};
        end else begin
            special = 0;
            ma = 64'(fa) | (64'd1 << 23);
            mb = 64'(fb) | (64'd1 << 23);
            num = ma << 30;
            qv = num / mb;
            st = (num % mb) != 0;
            e = int'(ea) - int'(eb) + 127;
            if (qv >= (64'd1 << 30)) sh = 7;
            else begin sh = 6; e = e - 1; end
            mant = qv >> sh;
            low  = qv & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up = (low > half) || ((low == half) && (st || mant[0]));
            nx = (low != 0) || st;
            mant = mant + 64'(up);
            if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; f = 5'b00101;
            end else if (e <= 0) begin
                r = {s, 31'd0}; f = 5'b00011;
            end else begin
                r = {s, e[7:0], mant[22:0]}; f = {4'b0, nx};
            end
        end
    endfunction

    // Issue one request at a negedge and wait (bounded) for done.
    // inj>0 pulses start with a=b=0 in that cycle to probe the busy-ignore rule.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int inj,
                          output logic [31:0] res, output logic [4:0] fl,
                          output int lat, output bit busy_ok);
        busy_ok = 1; lat = 0;
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
            end
            if (lat == inj) begin
                bus.start = 1'b1; bus.a = 32'h0; bus.b = 32'h0;
            end else if (inj > 0 && lat == inj + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                if (bus.busy) busy_ok = 0;
                break;
            end
            if (!bus.busy) busy_ok = 0;
        end
        res = bus.result; fl = bus.fflags;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.fflags} !== 39'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b result=%h fflags=%b, want all zero",
                     bus.busy, bus.done, bus.result, bus.fflags);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va[6] = '{32'h448C0000, 32'h447A0000, 32'h7F000000, 32'h00800000,
                               32'h3F800000, 32'hBF800000};
        logic [31:0] vb[6] = '{32'hC2F00000, 32'h41000000, 32'h3E800000, 32'h7F000000,
                               32'h40400000, 32'h3F800000};
        logic [31:0] vr[6] = '{32'hC1155555, 32'h42FA0000, 32'h7F800000, 32'h00000000,
                               32'h3EAAAAAB, 32'hBF800000};
        logic [4:0]  vf[6] = '{5'b00001, 5'b00000, 5'b00101, 5'b00011, 5'b00001, 5'b00000};
        logic [31:0] res; logic [4:0] fl; int lat; bit bok;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], 0, res, fl, lat, bok);
            checks++;
            if (res !== vr[i] || fl !== vf[i]) begin
                failures++;
                $display("FAIL directed_%0d: result=%h fflags=%b, want %h %b", i, res, fl, vr[i], vf[i]);
            end
            checks++;
            if (lat !== 28 || !bok) begin
                failures++;
                $display("FAIL directed_latency_%0d: latency=%0d busy_ok=%0d, want 28 1", i, lat, bok);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[9] = '{32'h3F800000, 32'h00000000, 32'h7F800001, 32'h7FC00000, 32'h7F800000,
                               32'h7F800000, 32'hC0000000, 32'h00000001, 32'h3F800000};
        logic [31:0] vb[9] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                               32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h80000005};
        logic [31:0] vr[9] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                               32'h7FC00000, 32'h80000000, 32'h00000000, 32'hFF800000};
        logic [4:0]  vf[9] = '{5'b01000, 5'b10000, 5'b10000, 5'b00000, 5'b00000,
                               5'b10000, 5'b00000, 5'b00000, 5'b01000};
        logic [31:0] res; logic [4:0] fl; int lat; bit bok;
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], 0, res, fl, lat, bok);
            checks++;
            if (res !== vr[i] || fl !== vf[i] || lat !== 1) begin
                failures++;
                $display("FAIL special_%0d: result=%h fflags=%b latency=%0d, want %h %b 1",
                         i, res, fl, lat, vr[i], vf[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] res; logic [4:0] fl; int lat; bit bok;
        run_op(32'h447A0000, 32'h41000000, 10, res, fl, lat, bok);
        checks++;
        if (res !== 32'h42FA0000 || fl !== 5'b0 || lat !== 28 || !bok) begin
            failures++;
            $display("FAIL start_while_busy: result=%h fflags=%b latency=%0d busy_ok=%0d, want 42fa0000 0 28 1",
                     res, fl, lat, bok);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h42FA0000) begin
            failures++;
            $display("FAIL hold_after_done: busy=%b done=%b result=%h, want 0 0 42fa0000",
                     bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic [4:0] fl; int lat; bit bok;
        run_op(32'h448C0000, 32'hC2F00000, 0, res, fl, lat, bok);
        // start raised during the DONE cycle must be dropped
        bus.a = 32'h0; bus.b = 32'h0; bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'hC1155555) begin
            failures++;
            $display("FAIL start_in_done: done=%b busy=%b result=%h, want 0 0 c1155555",
                     bus.done, bus.busy, bus.result);
        end
        run_op(32'h447A0000, 32'h41000000, 0, res, fl, lat, bok);
        checks++;
        if (res !== 32'h42FA0000 || fl !== 5'b0 || lat !== 28) begin
            failures++;
            $display("FAIL back_to_back: result=%h fflags=%b latency=%0d, want 42fa0000 0 28", res, fl, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] res; logic [4:0] fl; int lat; bit bok; bit saw_done;
        bus.a = 32'h448C0000; bus.b = 32'hC2F00000; bus.start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.result, bus.fflags} !== 39'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b result=%h fflags=%b, want all zero",
                     bus.busy, bus.done, bus.result, bus.fflags);
        end
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_abort: done or busy seen after reset, want none");
        end
        run_op(32'h447A0000, 32'h41000000, 0, res, fl, lat, bok);
        checks++;
        if (res !== 32'h42FA0000 || fl !== 5'b0 || lat !== 28 || !bok) begin
            failures++;
            $display("FAIL after_reset: result=%h fflags=%b latency=%0d busy_ok=%0d, want 42fa0000 0 28 1",
                     res, fl, lat, bok);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] sp[8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                               32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h3F800000};
        if ($urandom_range(0, 9) == 0) return sp[$urandom_range(0, 7)];
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] av, bv, er, res; logic [4:0] ef, fl; bit sp, bok; int lat;
        for (int i = 0; i < 60; i++) begin
            av = rand_fp(); bv = rand_fp();
            if (i % 4 == 0) bv[30:23] = av[30:23]; // exercise quotient near 1.0
            model(av, bv, er, ef, sp);
            run_op(av, bv, 0, res, fl, lat, bok);
            checks++;
            if (res !== er || fl !== ef || lat !== (sp ? 1 : 28) || !bok) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h: result=%h fflags=%b latency=%0d busy_ok=%0d, want %h %b %0d",
                         i, av, bv, res, fl, lat, bok, er, ef, sp ? 1 : 28);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            else begin @(negedge clk); @(negedge clk); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_directed();
        test_specials();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
